compare_exchange_stage: RTL

COMPARE_EXCHANGE_STAGE -- requirements
Module: compare_exchange_stage

---
 rtl/compare_exchange_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/compare_exchange_stage.sv
// Compare-exchange stage for bitonic-style sorting networks.
// Pairs lane i with lane i+STRIDE, orders each pair per its direction bit,
// carries tags with values, and counts swaps. One output register plus a
// skid register give full throughput with a registered in_ready.
// Ports:
//   clk, reset (sync, active-low)
//   in_data/in_index/in_dir/in_valid -> in_ready   : upstream beat
//   out_data/out_index/out_swaps/out_valid <- out_ready : downstream beat
module compare_exchange_stage #(
    parameter int LANES       = 8,
    parameter int STRIDE      = 1,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LANES*DATA_WIDTH-1:0]       in_data,
    input  logic [LANES*INDEX_WIDTH-1:0]      in_index,
    input  logic [LANES/2-1:0]                in_dir,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [LANES*DATA_WIDTH-1:0]       out_data,
    output logic [LANES*INDEX_WIDTH-1:0]      out_index,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(LANES/2+1)-1:0]      out_swaps
);

    localparam int PAIRS = LANES / 2;
    localparam int SW    = $clog2(PAIRS + 1);
    localparam int SSAFE = (STRIDE < 1) ? 1 : STRIDE;

    generate
        if (LANES < 2 || (LANES % 2) != 0 || STRIDE < 1 ||
            (LANES % (2 * SSAFE)) != 0) begin : g_bad_params
            $error("compare_exchange_stage: illegal LANES/STRIDE");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Exchanged view of the current input beat
    logic [LANES*DATA_WIDTH-1:0]  ex_data;
    logic [LANES*INDEX_WIDTH-1:0] ex_index;
    logic [SW-1:0]                ex_swaps;
    logic [DATA_WIDTH-1:0]        va, vb;
    logic [INDEX_WIDTH-1:0]       ia, ib;
    logic                         hi_above, hi_below, do_swap;
    int                           lo, hi;

    always_comb begin
        ex_data  = in_data;
        ex_index = in_index;
        ex_swaps = '0;
        va       = '0;
        vb       = '0;
        ia       = '0;
        ib       = '0;
        hi_above = 1'b0;
        hi_below = 1'b0;
        do_swap  = 1'b0;
        lo       = 0;
        hi       = 0;
        for (int p = 0; p < PAIRS; p++) begin
            // p-th pair in ascending order of its low lane
            lo = (p / SSAFE) * 2 * SSAFE + (p % SSAFE);
            hi = lo + SSAFE;
            va = in_data[lo*DATA_WIDTH +: DATA_WIDTH];
            vb = in_data[hi*DATA_WIDTH +: DATA_WIDTH];
            ia = in_index[lo*INDEX_WIDTH +: INDEX_WIDTH];
            ib = in_index[hi*INDEX_WIDTH +: INDEX_WIDTH];
            // (value, index) ordering; equal keys never swap
            hi_above = (vb > va) || (vb == va && ib > ia);
            hi_below = (vb < va) || (vb == va && ib < ia);
            do_swap  = in_dir[p] ? hi_above : hi_below;
            if (do_swap) begin
                ex_data[lo*DATA_WIDTH +: DATA_WIDTH]    = vb;
                ex_data[hi*DATA_WIDTH +: DATA_WIDTH]    = va;
                ex_index[lo*INDEX_WIDTH +: INDEX_WIDTH] = ib;
                ex_index[hi*INDEX_WIDTH +: INDEX_WIDTH] = ia;
                ex_swaps = ex_swaps + SW'(1);
            end
        end
    end

    state_e                       state_q, state_d;
    logic                         in_ready_q, in_ready_d;
    logic [LANES*DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [LANES*INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [SW-1:0]                out_swaps_q, out_swaps_d;
    logic [LANES*DATA_WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [LANES*INDEX_WIDTH-1:0] skid_index_q, skid_index_d;
    logic [SW-1:0]                skid_swaps_q, skid_swaps_d;
    logic                         in_xfer, out_xfer;

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        out_swaps_d  = out_swaps_q;
        skid_data_d  = skid_data_q;
        skid_index_d = skid_index_q;
        skid_swaps_d = skid_swaps_q;
        in_xfer      = in_valid && in_ready_q;
        out_xfer     = (state_q != EMPTY) && out_ready;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_data_d  = ex_data;
                    out_index_d = ex_index;
                    out_swaps_d = ex_swaps;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_data_d  = ex_data;
                    skid_index_d = ex_index;
                    skid_swaps_d = ex_swaps;
                    state_d      = FULL;
                end else if (in_xfer) begin
                    out_data_d  = ex_data;
                    out_index_d = ex_index;
                    out_swaps_d = ex_swaps;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    out_data_d  = skid_data_q;
                    out_index_d = skid_index_q;
                    out_swaps_d = skid_swaps_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered view of "skid register empty" for the next cycle
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_swaps_q  <= '0;
            skid_data_q  <= '0;
            skid_index_q <= '0;
            skid_swaps_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_swaps_q  <= out_swaps_d;
            skid_data_q  <= skid_data_d;
            skid_index_q <= skid_index_d;
            skid_swaps_q <= skid_swaps_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_swaps = out_swaps_q;

endmodule
